// File: rtl/cmd_dispatcher_if.sv
// Avalon-MM slave port bundle for the sprite command dispatcher.
// Groups the address/strobe/data/waitrequest signals of the HPS-facing port.
interface cmd_dispatcher_if;
    logic        avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;

    modport master (
        output avs_address, avs_write, avs_writedata, avs_read,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_write, avs_writedata, avs_read,
        output avs_readdata, avs_waitrequest
    );
endinterface

// File: rtl/cmd_dispatcher.sv
// cmd_dispatcher: buffers 32-bit sprite commands from the HPS in a FIFO and
// broadcasts them one per cycle on the shared display command bus. Buffer-swap
// commands (info==4'hF) are held until vertical blank, at most one per frame.
// Optional feature macro: CMD_DISPATCH_GUARD_EN -- drops normal writes aimed at
// the buffer currently on screen and counts them in a saturating drop counter.
//
// Handshake: a write is taken on a rising edge where avs_write=1 and
// avs_waitrequest=0; while avs_waitrequest=1 (FIFO full) the master must hold
// the write and re-present it. Reads return data in the same cycle.
module cmd_dispatcher #(
    parameter int DEPTH    = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic              clk,
    input  logic              reset_n,
    cmd_dispatcher_if.slave   avs,
    input  logic [9:0]        vcount,
    output logic [31:0]       cmd_out,
    output logic              front_buf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [9:0] V_ACT = 10'(V_ACTIVE);
    localparam logic [9:0] V_TOT = 10'(V_TOTAL);

    typedef enum logic [1:0] {
        DISPATCH  = 2'd0,
        WAIT_VB   = 2'd1,
        SWAP_DONE = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            swapped;
    logic [31:0]     drop_cnt;
    logic [31:0]     rdata;

    logic            full, empty, push, pop, drive, take_swap, drop;
    logic            vblank, head_swap, guard_hit;
    logic [31:0]     head;
    logic [8:0]      fill;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = avs.avs_write && !avs.avs_address && !full;
    assign head      = mem[rd_ptr];
    assign head_swap = (head[20:17] == 4'hF);
    assign vblank    = (vcount >= V_ACT) && (vcount < V_TOT);
    assign fill      = 9'(count);

`ifdef CMD_DISPATCH_GUARD_EN
    // A normal write targeting the displayed buffer would tear the frame.
    assign guard_hit = (head[20:17] == 4'h1) && (head[13] == front_buf);
`else
    assign guard_hit = 1'b0;
`endif

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= avs.avs_writedata;
    end

    // Next-state and pop/drive decisions for the dispatch FSM.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        drive      = 1'b0;
        take_swap  = 1'b0;
        drop       = 1'b0;
        case (state)
            DISPATCH: begin
                if (!empty) begin
                    if (head_swap) begin
                        state_next = WAIT_VB;
                    end else begin
                        pop = 1'b1;
                        if (guard_hit) drop  = 1'b1;
                        else           drive = 1'b1;
                    end
                end
            end
            WAIT_VB: begin
                // Swap stays at the head so later commands keep their order.
                if (swapped) begin
                    state_next = SWAP_DONE;
                end else if (vblank) begin
                    pop        = 1'b1;
                    drive      = 1'b1;
                    take_swap  = 1'b1;
                    state_next = DISPATCH;
                end
            end
            SWAP_DONE: begin
                if (!swapped) state_next = WAIT_VB;
            end
            default: state_next = DISPATCH;
        endcase
    end

    // State, FIFO pointers, command bus and swap bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= DISPATCH;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_out   <= '0;
            front_buf <= 1'b0;
            swapped   <= 1'b0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            cmd_out <= drive ? head : 32'h0;
            if (take_swap) front_buf <= head[13];
            if (vcount < V_ACT)  swapped <= 1'b0;
            else if (take_swap)  swapped <= 1'b1;
        end
    end

    // Saturating count of guarded (discarded) writes; address-1 write clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else begin
`ifdef CMD_DISPATCH_GUARD_EN
            if (avs.avs_write && avs.avs_address && !full)
                drop_cnt <= '0;
            else if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
`else
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + 1'b1;
`endif
        end
    end

    // Zero-latency read mux: status word or drop counter.
    always_comb begin
        rdata = '0;
        if (avs.avs_read) begin
            if (avs.avs_address) rdata = drop_cnt;
            else rdata = {16'b0, fill, 3'b0, state, swapped, front_buf};
        end
    end

    assign avs.avs_readdata    = rdata;
    assign avs.avs_waitrequest = full;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: directed scenarios followed by a randomized run
// checked against an order-level command model.
module tb_cmd_dispatcher;
`ifdef CMD_DISPATCH_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  vcount;
    logic [31:0] cmd_out;
    logic        front_buf;

    int vectors = 0;
    int miscompares = 0;

    cmd_dispatcher_if bus();

    cmd_dispatcher #(.DEPTH(16), .V_ACTIVE(480), .V_TOTAL(525)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .avs       (bus),
        .vcount    (vcount),
        .cmd_out   (cmd_out),
        .front_buf (front_buf)
    );

    // clock
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] exp_q[$];
    int          model_front;
    int          shown_front;
    int          drops;
    bit          swap_in_vb;
    logic [9:0]  prev_vc;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] mk(input int hi, input int info, input int pp, input int low);
        return (32'(hi) << 21) | (32'(info) << 17) | (32'(pp) << 13) | 32'(low);
    endfunction

    function automatic logic [31:0] status(input int fill, input int st, input int sw, input int fr);
        return 32'(fill * 128 + st * 4 + sw * 2 + fr);
    endfunction

    task automatic rd(input logic a, output logic [31:0] d);
        bus.avs_address = a;
        #1 d = bus.avs_readdata;
    endtask

    task automatic put(input logic a, input logic [31:0] d);
        bus.avs_address   = a;
        bus.avs_writedata = d;
        bus.avs_write     = 1'b1;
        tick();
        bus.avs_write     = 1'b0;
    endtask

    // One randomized cycle: score the previous edge's output, then drive.
    task automatic rnd_cycle(input bit gen);
        logic [31:0] w, expv;
        int info, pp;
        if (prev_vc < 10'd480) swap_in_vb = 1'b0;
        if (cmd_out !== 32'h0) begin
            if (exp_q.size() == 0) begin
                check("rnd_extra", cmd_out, 32'h0);
            end else begin
                expv = exp_q.pop_front();
                check("rnd_order", cmd_out, expv);
                if (expv[20:17] == 4'hF) begin
                    check("rnd_swap_vb", {31'b0, prev_vc >= 10'd480}, 32'd1);
                    check("rnd_swap_once", {31'b0, swap_in_vb}, 32'd0);
                    swap_in_vb  = 1'b1;
                    shown_front = int'(expv[13]);
                end
            end
        end
        check("rnd_front", {31'b0, front_buf}, 32'(shown_front));
        bus.avs_write = 1'b0;
        if (gen && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 39)) inside
                [0:0]:   info = 15;
                [1:24]:  info = 1;
                default: info = int'($urandom_range(0, 14));
            endcase
            pp = int'($urandom_range(0, 1));
            w  = mk(int'($urandom_range(0, 2047)), info, pp, int'($urandom_range(1, 8191)));
            bus.avs_address   = 1'b0;
            bus.avs_writedata = w;
            bus.avs_write     = 1'b1;
            if (!bus.avs_waitrequest) begin
                if (info == 15) begin
                    exp_q.push_back(w);
                    model_front = pp;
                end else if (GUARD_EN && info == 1 && pp == model_front) begin
                    drops++;
                end else begin
                    exp_q.push_back(w);
                end
            end
        end
        prev_vc = vcount;
        tick();
        vcount = (vcount == 10'd524) ? 10'd0 : vcount + 10'd1;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] words [1:16];
        logic [31:0] swp1, swpa, swpb, swpc, gw0, gw1, gw2;

        // reset block
        bus.avs_address   = 1'b0;
        bus.avs_write     = 1'b0;
        bus.avs_writedata = 32'h0;
        bus.avs_read      = 1'b1;
        vcount            = 10'd100;
        reset_n           = 1'b0;
        repeat (3) tick();
        check("rst_cmd", cmd_out, 32'h0);
        check("rst_front", {31'b0, front_buf}, 32'd0);
        check("rst_wait", {31'b0, bus.avs_waitrequest}, 32'd0);
        rd(1'b0, d); check("rst_status", d, 32'h0);
        rd(1'b1, d); check("rst_drop", d, 32'h0);
        reset_n = 1'b1;
        tick();

        // single write latency
        bus.avs_address   = 1'b0;
        bus.avs_writedata = 32'h4002_6001;
        bus.avs_write     = 1'b1;
        check("t1_wait", {31'b0, bus.avs_waitrequest}, 32'd0);
        tick();
        bus.avs_write = 1'b0;
        check("t1_lat", cmd_out, 32'h0);
        rd(1'b0, d); check("t1_fill", d, status(1, 0, 0, 0));
        tick(); check("t1_out", cmd_out, 32'h4002_6001);
        tick(); check("t1_hold", cmd_out, 32'h0);

        // swap blocks the head while 16 more writes fill the FIFO
        swp1 = mk(0, 15, 1, 0);
        bus.avs_writedata = swp1;
        bus.avs_write     = 1'b1;
        tick();
        for (int i = 1; i <= 15; i++) begin
            words[i] = mk(i, 1, 0, i);
            bus.avs_writedata = words[i];
            check("t2_wait_lo", {31'b0, bus.avs_waitrequest}, 32'd0);
            tick();
            check("t2_held", cmd_out, 32'h0);
        end
        words[16] = mk(16, 1, 0, 16);
        bus.avs_writedata = words[16];
        check("t2_full", {31'b0, bus.avs_waitrequest}, 32'd1);
        rd(1'b0, d); check("t2_status", d, status(16, 1, 0, 0));
        tick();
        check("t2_stall", {31'b0, bus.avs_waitrequest}, 32'd1);
        check("t2_idle", cmd_out, 32'h0);
        vcount = 10'd480;
        tick();
        check("t3_swap", cmd_out, swp1);
        check("t3_front", {31'b0, front_buf}, 32'd1);
        check("t3_wait", {31'b0, bus.avs_waitrequest}, 32'd0);
        rd(1'b0, d); check("t3_status", d, status(15, 0, 1, 1));
        for (int i = 1; i <= 16; i++) begin
            tick();
            bus.avs_write = 1'b0;
            check("t2_drain", cmd_out, words[i]);
        end
        tick(); check("t2_done", cmd_out, 32'h0);

        // two swaps in one frame
        vcount = 10'd0;
        repeat (3) tick();
        vcount = 10'd479;
        swpa = mk(1, 15, 0, 10);
        swpb = mk(2, 15, 1, 11);
        put(1'b0, swpa);
        put(1'b0, swpb);
        tick(); check("t4_pre", cmd_out, 32'h0);
        vcount = 10'd480;
        tick();
        check("t4_first", cmd_out, swpa);
        check("t4_front_a", {31'b0, front_buf}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick(); check("t4_block", cmd_out, 32'h0);
        end
        rd(1'b0, d); check("t4_swap_done", d, status(1, 2, 1, 0));
        vcount = 10'd524;
        tick(); check("t4_vb_end", cmd_out, 32'h0);
        vcount = 10'd0;
        for (int i = 0; i < 4; i++) begin
            tick(); check("t4_active", cmd_out, 32'h0);
        end
        rd(1'b0, d); check("t4_rearmed", d, status(1, 1, 0, 0));
        vcount = 10'd480;
        tick();
        check("t4_second", cmd_out, swpb);
        check("t4_front_b", {31'b0, front_buf}, 32'd1);
        tick(); check("t4_after", cmd_out, 32'h0);

        // reset while a swap waits for vblank
        vcount = 10'd100;
        swpc = mk(3, 15, 0, 12);
        put(1'b0, swpc);
        tick(); tick();
        rd(1'b0, d); check("t6_pending", d, status(1, 1, 0, 1));
        reset_n = 1'b0;
        #1;
        check("t6_front", {31'b0, front_buf}, 32'd0);
        check("t6_cmd", cmd_out, 32'h0);
        rd(1'b0, d); check("t6_status", d, 32'h0);
        tick();
        reset_n = 1'b1;
        vcount = 10'd480;
        for (int i = 0; i < 4; i++) begin
            tick(); check("t6_discard", cmd_out, 32'h0);
        end
        vcount = 10'd100;
        tick();

        // guard behaviour with front_buf=0
        gw0 = mk(4, 1, 0, 85);
        put(1'b0, gw0);
        check("t5_lat", cmd_out, 32'h0);
        tick(); check("t5_same_buf", cmd_out, GUARD_EN ? 32'h0 : gw0);
        rd(1'b1, d); check("t5_drop_cnt", d, GUARD_EN ? 32'd1 : 32'd0);
        put(1'b1, 32'h0);
        rd(1'b1, d); check("t5_drop_clr", d, 32'h0);
        gw1 = mk(5, 1, 1, 119);
        put(1'b0, gw1);
        tick(); check("t5_other_buf", cmd_out, gw1);
        gw2 = mk(6, 3, 0, 51);
        put(1'b0, gw2);
        tick(); check("t5_opaque", cmd_out, gw2);
        tick(); check("t5_idle", cmd_out, 32'h0);
        bus.avs_address = 1'b0;

        // randomized traffic with vcount sweeping frames
        model_front = 0;
        shown_front = 0;
        drops       = 0;
        swap_in_vb  = 1'b0;
        vcount      = 10'd0;
        prev_vc     = 10'd100;
        for (int c = 0; c < 3000; c++) rnd_cycle(1'b1);
        for (int c = 0; c < 12000 && exp_q.size() != 0; c++) rnd_cycle(1'b0);
        check("rnd_drained", 32'(exp_q.size()), 32'd0);
        for (int c = 0; c < 4; c++) rnd_cycle(1'b0);
        rd(1'b1, d); check("rnd_drops", d, 32'(drops));
        rd(1'b0, d); check("rnd_fill", (d >> 7) & 32'h1FF, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cmd_dispatcher.md
# cmd_dispatcher

Avalon-MM slave that buffers 32-bit sprite commands written by the HPS and broadcasts them, one per cycle, on the shared command bus. That bus feeds every display component: Flag, Mario, blocks and the rest. Buffer-swap commands are held until vertical blank so a frame is never torn. Exactly one swap is issued per frame. The block sits between the Avalon interconnect and the display components' `writedata` inputs.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, 4..256.
- `V_ACTIVE`, 480: first vcount line of vertical blank.
- `V_TOTAL`, 525: lines per frame; vcount range is 0..V_TOTAL-1.
- `clk` input 1: system clock, the single clock domain.
- `reset_n` input 1: reset, asynchronous assert, active-low.
- `avs_address` input 1: 0 = status/command, 1 = drop counter.
- `avs_write` input 1: write strobe; only address 0 enqueues.
- `avs_writedata` input 32: command word.
- `avs_read` input 1: read strobe.
- `avs_readdata` output 32: read data, zero read latency.
- `avs_waitrequest` output 1: equals `full`; stalls the master.
- `vcount` input 10: current VGA line.
- `cmd_out` output 32: command bus to display components; 0 = idle.
- `front_buf` output 1: ping/pong buffer currently displayed.

## Operation
- **Command fields:** info[20:17], pp_selc[13].
  - info==4'hF: swap command.
  - info==4'h1: normal write.
  - Any other info value: opaque, forwarded unchanged.
- **Enqueue:** when `avs_write && avs_address==0 && !full`. A write to address 1 clears the drop counter.
- **Read data:**
  - Address 0: {16'b0, fill[8:0], 3'b0, state[1:0], swapped, front_buf}.
  - Address 1: drop counter, 32-bit, saturating.
- **FSM states:** DISPATCH, WAIT_VB, SWAP_DONE.
  - **DISPATCH:** if the FIFO is non-empty and the head is not a swap, pop it and drive it on `cmd_out` for one cycle. If the head is a swap, go to WAIT_VB without popping.
  - **WAIT_VB:** `cmd_out`=0 and nothing is popped, so ordering is preserved. When vblank is active and `swapped`==0: pop the swap, drive it one cycle, set `front_buf`<=pp_selc and `swapped`<=1, then go to DISPATCH.
  - **SWAP_DONE:** not entered from DISPATCH directly. When a swap reaches the head while `swapped`==1, go to SWAP_DONE and wait for `swapped` to clear, then go to WAIT_VB.
- **vblank:** defined as `vcount >= V_ACTIVE`.
- **swapped flag:** cleared on any cycle with `vcount < V_ACTIVE`. Result: at most one swap per frame.
- **cmd_out hold:** `cmd_out` returns to 32'h0 on every cycle without a pop. A command is never presented for more than one cycle.
- **Simultaneous enqueue and pop:** fill is unchanged; the pointers wrap modulo DEPTH.
- **Full:** `avs_waitrequest`=1 and the write is not taken. The master re-presents the write, so no data is lost.
- **Empty:** nothing is popped; `cmd_out`=0.
- **Reset (asynchronous, any state):**
  - FIFO emptied; FSM to DISPATCH.
  - `cmd_out`=0, `front_buf`=0, `swapped`=0, drop counter=0.
  - `avs_waitrequest`=0, `avs_readdata`=0.
  - A swap pending at reset is discarded.

## Timing
- `cmd_out` and `front_buf` are registered. `avs_waitrequest`, `full` and `avs_readdata` are combinational from registers.
- **Latency, empty FIFO in DISPATCH:** a write accepted at edge t appears on `cmd_out` after edge t+1 and is held until edge t+2.
- **Throughput:** one command per cycle sustained.
- **Swap:** `front_buf` and the swap word on `cmd_out` change on the same edge.
- **Worst-case swap delay:** one frame plus the lines remaining in the current frame.

## Configuration
- `CMD_DISPATCH_GUARD_EN`
  - **Defined:** a normal write (info==4'h1) whose pp_selc equals the current `front_buf` is popped but not driven. `cmd_out` stays 0 that cycle and the drop counter increments. This protects the displayed buffer.
  - **Undefined:** every non-swap command is forwarded unchanged, the drop counter reads 0, and writes to address 1 have no effect.

## Test plan
- **Reset then single write:** reset_n low→high, write 32'h4002_6001 to address 0 → `cmd_out`=32'h4002_6001 for exactly one cycle after the next edge, then 0.
- **Back-to-back fill:** 17 writes with DEPTH=16 and vcount held at 100 → 17th write stalled with waitrequest=1. Dispatch drains at one word per cycle and all 17 words appear on `cmd_out` in order.
- **Swap before vblank:** vcount=100, enqueue swap (info=F, pp_selc=1) then a write → `cmd_out` stays 0 and the write is held. At vcount=480 the swap issues, `front_buf`=1, and the write follows the next cycle.
- **Two swaps in one frame:** both enqueued at vcount=479 → first issues at 480. Second waits in SWAP_DONE until vcount wraps to 0, then issues at the next vcount=480.
- **Guard, CMD_DISPATCH_GUARD_EN defined:** `front_buf`=0, write info=1 with pp_selc=0 → `cmd_out` stays 0 and address 1 reads 1. The same write with pp_selc=1 is forwarded.
- **Reset mid-WAIT_VB:** reset_n low with a swap pending → FIFO empty, `front_buf`=0, status reads 0.
